// File: rtl/ref_fetch_ctrl.sv
// Reference-window fetch sequencer: pulls reference beats over req/gnt/rvalid into a
// 4-bank rotating SRAM, exposes a 3-bank window and tracks line/frame progress.
module ref_fetch_ctrl #(
  parameter int unsigned ROWS            = 23,
  parameter int unsigned BLOCKS_PER_LINE = 482,
  parameter int unsigned LINES           = 270,
  parameter int unsigned ADDR_STEP       = 8,
  parameter int unsigned LINE_STRIDE     = 3856,
  parameter int unsigned MAX_OUT         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] frame_base,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        sram_me,
  output logic [4:0]  sram_adr,
  output logic [3:0]  sram_we,
  output logic [63:0] sram_d,
  output logic        win_valid,
  output logic [1:0]  win_bank,
  input  logic        win_consume,
  output logic        line_done,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned BeatsPerLine = BLOCKS_PER_LINE * ROWS;
  localparam logic [4:0]  RowLast      = 5'(ROWS - 1);
  localparam logic [3:0]  MaxOut       = 4'(MAX_OUT);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StLineEnd, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] base_q, base_d;
  logic [3:0]  out_q, out_d;
  logic [31:0] req_cnt_q, req_cnt_d;
  logic [4:0]  req_row_q, req_row_d;
  logic [2:0]  res_q, res_d;
  logic [4:0]  wr_row_q, wr_row_d;
  logic [1:0]  wr_bank_q, wr_bank_d;
  logic [2:0]  occ_q, occ_d;
  logic [1:0]  win_bank_q, win_bank_d;
  logic [31:0] blk_q, blk_d;
  logic [31:0] line_q, line_d;

  logic win_act, gnt, wr_en, wr_wrap, pop, reserve;

  assign win_act   = (state_q == StRun) || (state_q == StDrain);
  assign win_valid = win_act && (occ_q >= 3'd3);
  assign pop       = win_consume && win_valid;
  // Beats arriving with nothing outstanding are stray and must not touch the banks.
  assign wr_en     = mem_rvalid && (out_q != 4'd0);
  assign wr_wrap   = wr_en && (wr_row_q == RowLast);

  // A bank already started must be finished even when all four are reserved.
  assign mem_req = (state_q == StRun) && (out_q < MaxOut) &&
                   ((req_row_q != 5'd0) || (res_q < 3'd4)) && (req_cnt_q < BeatsPerLine);
  assign gnt     = mem_req && mem_gnt;
  assign reserve = gnt && (req_row_q == 5'd0);

  assign mem_addr = addr_q;
  assign busy     = (state_q != StIdle);
  assign sram_me  = busy;
  assign sram_adr = wr_row_q;
  assign sram_we  = wr_en ? (4'b0001 << wr_bank_q) : 4'b0000;
  assign sram_d   = wr_en ? mem_rdata : 64'd0;
  assign win_bank = win_bank_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    out_d      = out_q;
    req_cnt_d  = req_cnt_q;
    req_row_d  = req_row_q;
    res_d      = res_q;
    wr_row_d   = wr_row_q;
    wr_bank_d  = wr_bank_q;
    occ_d      = occ_q;
    win_bank_d = win_bank_q;
    blk_d      = blk_q;
    line_d     = line_q;
    line_done  = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d     = frame_base;
          addr_d     = frame_base;
          out_d      = 4'd0;
          req_cnt_d  = 32'd0;
          req_row_d  = 5'd0;
          res_d      = 3'd0;
          wr_row_d   = 5'd0;
          wr_bank_d  = 2'd0;
          occ_d      = 3'd0;
          win_bank_d = 2'd0;
          blk_d      = 32'd0;
          line_d     = 32'd0;
          state_d    = StRun;
        end
      end

      StRun, StDrain: begin
        if (gnt) begin
          addr_d    = addr_q + ADDR_STEP;
          req_cnt_d = req_cnt_q + 32'd1;
          req_row_d = (req_row_q == RowLast) ? 5'd0 : req_row_q + 5'd1;
        end
        case ({gnt, wr_en})
          2'b10:   out_d = out_q + 4'd1;
          2'b01:   out_d = out_q - 4'd1;
          default: out_d = out_q;
        endcase
        case ({reserve, pop})
          2'b10:   res_d = res_q + 3'd1;
          2'b01:   res_d = res_q - 3'd1;
          default: res_d = res_q;
        endcase
        if (wr_en) begin
          if (wr_wrap) begin
            wr_row_d  = 5'd0;
            wr_bank_d = wr_bank_q + 2'd1;
            blk_d     = blk_q + 32'd1;
          end else begin
            wr_row_d = wr_row_q + 5'd1;
          end
        end
        case ({wr_wrap, pop})
          2'b10:   occ_d = occ_q + 3'd1;
          2'b01:   occ_d = occ_q - 3'd1;
          default: occ_d = occ_q;
        endcase
        if (pop) begin
          win_bank_d = win_bank_q + 2'd1;
        end
        if ((state_q == StRun) && (blk_q == BLOCKS_PER_LINE)) begin
          state_d = StDrain;
        end else if ((state_q == StDrain) && (occ_q < 3'd3)) begin
          state_d = StLineEnd;
        end
      end

      StLineEnd: begin
        // The two trailing banks never form a full window and are dropped here.
        line_done  = 1'b1;
        base_d     = base_q + LINE_STRIDE;
        addr_d     = base_q + LINE_STRIDE;
        out_d      = 4'd0;
        req_cnt_d  = 32'd0;
        req_row_d  = 5'd0;
        res_d      = 3'd0;
        wr_row_d   = 5'd0;
        wr_bank_d  = 2'd0;
        occ_d      = 3'd0;
        win_bank_d = 2'd0;
        blk_d      = 32'd0;
        line_d     = line_q + 32'd1;
        state_d    = ((line_q + 32'd1) == LINES) ? StDone : StRun;
      end

      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= 32'd0;
      base_q     <= 32'd0;
      out_q      <= 4'd0;
      req_cnt_q  <= 32'd0;
      req_row_q  <= 5'd0;
      res_q      <= 3'd0;
      wr_row_q   <= 5'd0;
      wr_bank_q  <= 2'd0;
      occ_q      <= 3'd0;
      win_bank_q <= 2'd0;
      blk_q      <= 32'd0;
      line_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      out_q      <= out_d;
      req_cnt_q  <= req_cnt_d;
      req_row_q  <= req_row_d;
      res_q      <= res_d;
      wr_row_q   <= wr_row_d;
      wr_bank_q  <= wr_bank_d;
      occ_q      <= occ_d;
      win_bank_q <= win_bank_d;
      blk_q      <= blk_d;
      line_q     <= line_d;
    end
  end

endmodule
